// File: rtl/timer_pkg.sv
// Shared definitions for the multi-channel timer: channel state encoding and mode constants.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: limit register, counter and IDLE/RUN/DONE state machine advanced by a shared tick.
module timer_channel
    import timer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             load,
    input  logic [WIDTH-1:0] limit_in,
    input  logic             mode,
    input  logic             start,
    input  logic             stop,
    output logic             running,
    output logic             done,
    output logic             pulse,
    output logic [WIDTH-1:0] count
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             mode_q, mode_d;
    logic             pulse_q, pulse_d;
    logic             running_q, done_q;

    // Next-state logic; stop overrides start, and start overrides tick handling.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        count_d = count_q;
        pulse_d = 1'b0;
        if (load) begin
            limit_d = limit_in;
        end else begin
            limit_d = limit_q;
        end
        if (stop) begin
            state_d = IDLE;
            count_d = '0;
        end else if (start) begin
            state_d = RUN;
            count_d = '0;
            mode_d  = mode;
        end else begin
            case (state_q)
                RUN: begin
                    if (tick) begin
                        // >= rather than == so a limit lowered below count expires at once
                        if (count_q >= limit_q) begin
                            count_d = '0;
                            pulse_d = 1'b1;
                            state_d = (mode_q == MODE_PERIODIC) ? RUN : DONE;
                        end else begin
                            count_d = count_q + WIDTH'(1);
                        end
                    end else begin
                        count_d = count_q;
                    end
                end
                IDLE, DONE: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    // Channel registers; status flags are registered from the next state so done rises with the final pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            limit_q   <= '0;
            count_q   <= '0;
            mode_q    <= MODE_PERIODIC;
            pulse_q   <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            limit_q   <= limit_d;
            count_q   <= count_d;
            mode_q    <= mode_d;
            pulse_q   <= pulse_d;
            running_q <= (state_d == RUN);
            done_q    <= (state_d == DONE);
        end
    end

    assign running = running_q;
    assign done    = done_q;
    assign pulse   = pulse_q;
    assign count   = count_q;

endmodule

// File: rtl/multi_timer.sv
// N-channel programmable timer sharing one prescaler. Define TIMER_PRESCALE_EN to enable the
// prescaler; without it every clk cycle is a tick and the prescale port is ignored.
module multi_timer
    import timer_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int CHANNELS  = 4,
    parameter int PRE_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PRE_WIDTH-1:0]      prescale,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS*WIDTH-1:0] limit,
    input  logic [CHANNELS-1:0]       mode,
    input  logic [CHANNELS-1:0]       start,
    input  logic [CHANNELS-1:0]       stop,
    output logic [CHANNELS-1:0]       running,
    output logic [CHANNELS-1:0]       done,
    output logic [CHANNELS-1:0]       pulse_out,
    output logic [CHANNELS*WIDTH-1:0] count
);

    logic tick_s;

`ifdef TIMER_PRESCALE_EN
    logic [PRE_WIDTH-1:0] pre_q, pre_d;

    // Free-running prescaler; its phase is shared by all channels and never reset by start.
    always_comb begin
        if (pre_q >= prescale) begin
            pre_d  = '0;
            tick_s = 1'b1;
        end else begin
            pre_d  = pre_q + PRE_WIDTH'(1);
            tick_s = 1'b0;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
`else
    logic unused_prescale_s;

    assign unused_prescale_s = ^prescale;
    assign tick_s            = 1'b1;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        timer_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .tick    (tick_s),
            .load    (load[i]),
            .limit_in(limit[i*WIDTH +: WIDTH]),
            .mode    (mode[i]),
            .start   (start[i]),
            .stop    (stop[i]),
            .running (running[i]),
            .done    (done[i]),
            .pulse   (pulse_out[i]),
            .count   (count[i*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer: expected pulses go into a scoreboard queue that a negedge monitor drains.
module tb_multi_timer;

    localparam int W  = 16;
    localparam int CH = 2;
    localparam int PW = 8;

`ifdef TIMER_PRESCALE_EN
    localparam int PS_LO = 4;
    localparam int PS_HI = 6;
`else
    localparam int PS_LO = 2;
    localparam int PS_HI = 2;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [PW-1:0]     prescale;
    logic [CH-1:0]     load, mode, start, stop;
    logic [CH*W-1:0]   limit;
    logic [CH-1:0]     running, done, pulse_out;
    logic [CH*W-1:0]   count;

    typedef struct {
        int ch;
        int lo;
        int hi;
        bit oneshot;
    } exp_t;

    exp_t exp_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   s;

    multi_timer #(.WIDTH(W), .CHANNELS(CH), .PRE_WIDTH(PW)) dut (
        .clk      (clk),
        .rst      (rst),
        .prescale (prescale),
        .load     (load),
        .limit    (limit),
        .mode     (mode),
        .start    (start),
        .stop     (stop),
        .running  (running),
        .done     (done),
        .pulse_out(pulse_out),
        .count    (count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) step();
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    endtask

    task automatic push(input int ch, input int lo, input int hi, input bit oneshot);
        exp_t e;
        e.ch = ch; e.lo = lo; e.hi = hi; e.oneshot = oneshot;
        exp_q.push_back(e);
    endtask

    // Monitor: every pulse must match the oldest expectation; overdue expectations count as misses.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && cyc > exp_q[0].hi) begin
                n_checks++;
                $display("FAIL missed_pulse ch%0d: none by cycle %0d, expected in [%0d,%0d]",
                         exp_q[0].ch, cyc, exp_q[0].lo, exp_q[0].hi);
                void'(exp_q.pop_front());
            end
            for (int c = 0; c < CH; c++) begin
                if (pulse_out[c]) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL unexpected_pulse ch%0d at cycle %0d: got pulse, expected none", c, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.ch == c && cyc >= e.lo && cyc <= e.hi && (!e.oneshot || done[c]))
                            n_pass++;
                        else
                            $display("FAIL pulse ch%0d at cycle %0d done=%0b: expected ch%0d in [%0d,%0d] oneshot=%0b",
                                     c, cyc, done[c], e.ch, e.lo, e.hi, e.oneshot);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; prescale = '0; load = '0; mode = '0; start = '0; stop = '0; limit = '0;
        repeat (3) step();
        rst = 1'b0;

        // Reset then idle: everything stays zero.
        for (int i = 0; i < 20; i++) begin
            step();
            check("idle_outputs", {running, done, pulse_out, count}, 64'd0);
        end

        // Periodic ch0, limit 3, load and start together: pulses at +4, +8, +12.
        limit = {16'd0, 16'd3}; load = 2'b01; mode = 2'b00; start = 2'b01;
        step();
        load = 2'b00; start = 2'b00; s = cyc;
        push(0, s + 4, s + 4, 1'b0);
        push(0, s + 8, s + 8, 1'b0);
        push(0, s + 12, s + 12, 1'b0);
        check("start_running", running, 64'd1);
        wait_cyc(s + 2);
        check("count_at_2", count[W-1:0], 64'd2);
        wait_cyc(s + 13);
        check("running_ch1_silent", running, 64'd1);
        check("count_after_wrap", count[W-1:0], 64'd1);
        stop = 2'b01;
        step();
        stop = 2'b00;
        check("stop_running", running, 64'd0);
        check("stop_count", count[W-1:0], 64'd0);
        check("stop_pulse", pulse_out, 64'd0);

        // One-shot ch0, limit 1, prescale 2: single pulse, then DONE; restart fires again.
        prescale = 8'd2; limit = {16'd0, 16'd1}; load = 2'b01; mode = 2'b01; start = 2'b01;
        step();
        load = 2'b00; start = 2'b00; s = cyc;
        push(0, s + PS_LO, s + PS_HI, 1'b1);
        wait_cyc(s + 8);
        check("oneshot_done", done, 64'd1);
        check("oneshot_not_running", running, 64'd0);
        wait_cyc(s + 14);
        start = 2'b01;
        step();
        start = 2'b00; s = cyc;
        push(0, s + PS_LO, s + PS_HI, 1'b1);
        check("restart_running", running, 64'd1);
        wait_cyc(s + 8);
        check("restart_done", done, 64'd1);
        stop = 2'b01;
        step();
        stop = 2'b00;
        check("stop_from_done", done, 64'd0);
        prescale = 8'd0;

        // Start and stop together on a running channel: stop wins.
        limit = {16'd0, 16'd9}; load = 2'b01; mode = 2'b00; start = 2'b01;
        step();
        load = 2'b00; start = 2'b00; s = cyc;
        wait_cyc(s + 3);
        check("count_at_3", count[W-1:0], 64'd3);
        start = 2'b01; stop = 2'b01;
        step();
        start = 2'b00; stop = 2'b00;
        check("startstop_running", running, 64'd0);
        check("startstop_count", count[W-1:0], 64'd0);
        step(); step();
        check("startstop_stays_idle", running, 64'd0);

        // Lone start, then lower limit 9 -> 2 while count is 5: pulse on next tick, then every 3.
        start = 2'b01;
        step();
        start = 2'b00; s = cyc;
        wait_cyc(s + 5);
        check("count_at_5", count[W-1:0], 64'd5);
        limit = {16'd0, 16'd2}; load = 2'b01;
        step();
        load = 2'b00;
        check("count_after_load", count[W-1:0], 64'd6);
        push(0, s + 7, s + 7, 1'b0);
        push(0, s + 10, s + 10, 1'b0);
        push(0, s + 13, s + 13, 1'b0);
        wait_cyc(s + 14);
        check("count_after_reload", count[W-1:0], 64'd1);
        stop = 2'b01;
        step();
        stop = 2'b00;

        // Reset mid-run at count 7 clears outputs and the limit register.
        limit = {16'd0, 16'd20}; load = 2'b01; start = 2'b01;
        step();
        load = 2'b00; start = 2'b00; s = cyc;
        wait_cyc(s + 7);
        check("count_at_7", count[W-1:0], 64'd7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrun_reset_outputs", {running, done, pulse_out, count}, 64'd0);
        repeat (10) step();
        check("no_restart_after_reset", {running, done, count}, 64'd0);

        // Cleared limit 0 with prescale 0: pulse stays high every cycle until stopped.
        start = 2'b01;
        step();
        start = 2'b00; s = cyc;
        push(0, s + 1, s + 1, 1'b0);
        push(0, s + 2, s + 2, 1'b0);
        push(0, s + 3, s + 3, 1'b0);
        wait_cyc(s + 3);
        stop = 2'b01;
        step();
        stop = 2'b00;
        check("limit0_stopped_pulse", pulse_out, 64'd0);
        check("limit0_stopped_running", running, 64'd0);

        repeat (4) step();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multi_timer.md
# multi_timer

Parametrised multi-channel programmable timer, the successor to the single free-running limit timer. It gives N independent channels that share one clock prescaler. Each channel has its own latched limit, periodic or one-shot mode, start/stop control, and a one-cycle registered pulse. It drives display-refresh, digit-advance and debounce strobes in the segment-display designs.

## Interface
- WIDTH, 32: per-channel counter/limit width.
- CHANNELS, 4: number of independent channels (≥1).
- PRE_WIDTH, 16: prescaler width.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- prescale  in  PRE_WIDTH  shared tick divider; tick every prescale+1 clk cycles.
- load  in  CHANNELS  per-channel strobe: latch limit slice into channel limit register.
- limit  in  CHANNELS*WIDTH  flattened limits; channel i = bits [i*WIDTH +: WIDTH].
- mode  in  CHANNELS  0 = periodic, 1 = one-shot; sampled on start.
- start  in  CHANNELS  per-channel start/restart strobe.
- stop  in  CHANNELS  per-channel stop strobe.
- running  out  CHANNELS  channel in RUN state.
- done  out  CHANNELS  one-shot channel has expired (DONE state).
- pulse_out  out  CHANNELS  registered expiry pulse.
- count  out  CHANNELS*WIDTH  current channel counters, flattened as limit.

## Operation
- Prescaler: free-running counter pre. On each clk, if pre >= prescale then pre <= 0 and tick = 1; otherwise pre + 1. Start does not reset it.
- Per-channel state: IDLE, RUN, DONE. limit_q, mode_q and count reset to 0.
- IDLE or DONE: start leads to RUN with count <= 0 and mode_q <= mode.
- RUN, tick, count >= limit_q: count <= 0, pulse_out <= 1. Periodic stays in RUN. One-shot goes to DONE.
- RUN, tick, count < limit_q: count <= count + 1 (WIDTH bits; wrap cannot occur because the >= compare fires first).
- RUN with start: restart, count <= 0, mode re-sampled, no pulse this cycle.
- Any state with stop: go to IDLE, count <= 0, pulse_out <= 0.
- start and stop in the same cycle: stop wins.
- load: limit_q <= limit slice in any state, effective from the next cycle.
  - Lowering the limit below count fires on the next tick.
  - load and start in the same cycle: the run uses the new limit from its first compare.
- pulse_out is low in every cycle not following an expiry edge.
- limit_q = 0 with prescale = 0 (periodic): pulse_out stays high continuously.
- running = (state == RUN). done = (state == DONE).

## Timing
- Reset values: every output is 0, all state is IDLE, pre = 0.
- rst mid-run: next cycle all outputs are 0, limits are cleared, and nothing restarts until the next start.
- Start latency: running high the cycle after the start edge.
- Period: (limit_q + 1) * (prescale + 1) clk cycles between pulses.
- With prescale = 0, the first pulse comes limit_q + 1 cycles after the start edge.
- With prescale > 0, the first interval can be short by up to prescale cycles, because the prescaler phase is shared.
- pulse_out width: exactly 1 clk per expiry, except in the continuous case above.
- done is set in the same cycle as the final one-shot pulse.

## Configuration
- TIMER_PRESCALE_EN defined: shared prescaler as described.
- TIMER_PRESCALE_EN undefined: no prescaler logic; tick = 1 every cycle; the prescale port exists but is ignored; period = limit_q + 1.

## Structure
- Package timer_pkg holds:
  - the state encoding (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2);
  - mode constants MODE_PERIODIC = 1'b0 and MODE_ONESHOT = 1'b1.
- Sub-module timer_channel: one channel's state machine, limit register and counter. It takes clk, rst, tick and per-channel slices, and is instantiated CHANNELS times in a generate loop.
- The top level holds the prescaler plus port slicing.

## Test plan
- Reset then idle: all outputs 0 for 20 cycles with no start.
- CHANNELS = 2, prescale = 0, ch0 limit = 3 periodic, start: pulse_out[0] on cycles 4, 8, 12 after start. ch1 stays silent.
- prescale = 2, limit = 1 one-shot: exactly one pulse, 6 cycles period-equivalent. done = 1 and running = 0 afterward. A restart produces a new pulse.
- Simultaneous start and stop on a running channel: goes to IDLE and count = 0. The next lone start runs normally.
- load limit = 2 while count = 5 with limit_q = 9: pulse on the next tick, then period 3.
- rst asserted mid-run with count = 7: outputs 0 the next cycle, limit_q = 0, state IDLE.
